poly_voice_player: RTL and testbench

Parametrised N-voice successor to the fixed three-voice chord player. It holds VOICES independent note slots, each with its own phase accumulator and beat-driven duration counter, and generates square, saw or triangle waveforms. A sequential mixer sums the voices into one signed sample per codec request. It sits between the song reader (load/done handshakes) and the codec conditioner (generate_next_sample / new_sample_ready), with the beat generator feeding `beat`.

---
 rtl/poly_voice_player.sv | 251 +++++++++++++++++++++++++
 tb/tb_poly_voice_player.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_voice_player.sv
`default_nettype none
// ============================================================================
// Module      : poly_voice_player
// Description : N-voice note player. Each voice slot holds a phase
//               accumulator, a phase step and a beat-driven duration counter.
//               A sequential mixer visits one voice per cycle, sums square,
//               saw or triangle waveforms and emits one signed sample per
//               codec request.
//
// Ports
//   clk                  : system clock, all state on rising edge
//   reset                : asynchronous, active-low; clears all state
//   play_enable          : high = voices advance and samples are produced
//   load_voice           : per-voice one-cycle load strobe
//   step_in              : voice i phase step at [i*STEP_W +: STEP_W]
//   duration_in          : voice i duration (beats) at [i*DUR_W +: DUR_W]
//   wave_sel             : 0 square, 1 saw, 2 triangle, 3 silence
//   beat                 : one-cycle beat pulse
//   generate_next_sample : one-cycle sample request from the codec side
//   done_with_note       : one-cycle pulse per voice when its note ends
//   voice_active         : level, voice currently sounding
//   sample_out           : signed mixed sample, held between updates
//   new_sample_ready     : one-cycle pulse, sample_out freshly updated
//   overrun              : sticky, a request arrived while the mixer was busy
//
// Revision    : 1.0 - initial release
// ============================================================================
module poly_voice_player #(
    parameter int VOICES   = 4,
    parameter int SAMPLE_W = 16,
    parameter int PHASE_W  = 20,
    parameter int STEP_W   = 20,
    parameter int DUR_W    = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       play_enable,
    input  logic [VOICES-1:0]          load_voice,
    input  logic [VOICES*STEP_W-1:0]   step_in,
    input  logic [VOICES*DUR_W-1:0]    duration_in,
    input  logic [1:0]                 wave_sel,
    input  logic                       beat,
    input  logic                       generate_next_sample,
    output logic [VOICES-1:0]          done_with_note,
    output logic [VOICES-1:0]          voice_active,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       new_sample_ready,
    output logic                       overrun
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_SHIFT = $clog2(VOICES);
    localparam int c_IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int c_ACC_W = SAMPLE_W + c_SHIFT;

    // Square wave levels: +/- a quarter of full scale.
    localparam logic [SAMPLE_W-1:0] c_SQ_POS = {2'b01, {(SAMPLE_W-2){1'b0}}};
    localparam logic [SAMPLE_W-1:0] c_SQ_NEG = {2'b11, {(SAMPLE_W-2){1'b0}}};

    // ------------------------------------------------------------------------
    // Mixer state
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [c_IDX_W-1:0]          r_idx;
    logic signed [c_ACC_W-1:0]   r_acc;
    logic signed [SAMPLE_W-1:0]  r_sample;
    logic                        r_nsr;
    logic                        r_overrun;

    logic                        w_start;
    logic                        w_last;
    logic                        w_mixing;

    // Per-voice views used by the mixer.
    logic [PHASE_W-1:0]          w_phase [VOICES];
    logic [VOICES-1:0]           w_active;
    logic [VOICES-1:0]           w_done;

    assign w_mixing = (r_state == S_ACCUM);
    assign w_start  = (r_state == S_IDLE) && generate_next_sample && play_enable;
    assign w_last   = (r_idx == c_IDX_W'(VOICES-1));

    // ------------------------------------------------------------------------
    // Voice slots
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
            logic [STEP_W-1:0]  r_step;
            logic [DUR_W-1:0]   r_dur;
            logic [PHASE_W-1:0] r_phase;
            logic               r_active;
            logic               r_done;
            logic [DUR_W-1:0]   w_load_dur;
            logic               w_advance;

            assign w_load_dur = duration_in[gi*DUR_W +: DUR_W];

            // The phase only moves when the mixer visits this voice, so every
            // sample sees each voice advance exactly once.
            assign w_advance = play_enable && r_active && w_mixing &&
                               (r_idx == c_IDX_W'(gi));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_step   <= '0;
                    r_dur    <= '0;
                    r_phase  <= '0;
                    r_active <= 1'b0;
                    r_done   <= 1'b0;
                end else begin
                    r_done <= 1'b0;
                    if (load_voice[gi]) begin
                        // A load takes priority over both a beat and a phase
                        // advance landing in the same cycle.
                        r_step   <= step_in[gi*STEP_W +: STEP_W];
                        r_dur    <= w_load_dur;
                        r_phase  <= '0;
                        r_active <= (w_load_dur != '0);
                        r_done   <= (w_load_dur == '0);
                    end else begin
                        if (w_advance) begin
                            r_phase <= r_phase + PHASE_W'(r_step);
                        end
                        if (beat && play_enable && r_active) begin
                            r_dur <= r_dur - DUR_W'(1);
                            if (r_dur == DUR_W'(1)) begin
                                r_active <= 1'b0;
                                r_done   <= 1'b1;
                            end
                        end
                    end
                end
            end

            assign w_phase[gi]  = r_phase;
            assign w_active[gi] = r_active;
            assign w_done[gi]   = r_done;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Waveform of the voice currently visited by the mixer
    // ------------------------------------------------------------------------
    logic [PHASE_W-1:0]         w_cur_phase;
    logic                       w_cur_active;
    logic [SAMPLE_W-1:0]        w_p;
    logic [SAMPLE_W-1:0]        w_tri_fold;
    logic [SAMPLE_W-1:0]        w_tri_dbl;
    logic [SAMPLE_W-1:0]        w_wave;
    logic signed [c_ACC_W-1:0]  w_wave_ext;
    logic signed [c_ACC_W-1:0]  w_sum;
    logic signed [c_ACC_W-1:0]  w_mixed;

    assign w_cur_phase  = w_phase[r_idx];
    assign w_cur_active = w_active[r_idx];

    always_comb begin
        w_p        = w_cur_phase[PHASE_W-1 -: SAMPLE_W];
        // Triangle: fold the upper half back down, then double the slope.
        w_tri_fold = w_p[SAMPLE_W-1] ? ~w_p : w_p;
        w_tri_dbl  = {w_tri_fold[SAMPLE_W-2:0], 1'b0};
        w_wave     = '0;
        if (w_cur_active) begin
            case (wave_sel)
                2'd0:    w_wave = w_p[SAMPLE_W-1] ? c_SQ_NEG : c_SQ_POS;
                2'd1:    w_wave = {~w_p[SAMPLE_W-1], w_p[SAMPLE_W-2:0]};
                2'd2:    w_wave = {~w_tri_dbl[SAMPLE_W-1], w_tri_dbl[SAMPLE_W-2:0]};
                default: w_wave = '0;
            endcase
        end
    end

    // Sign-extend the voice sample into the wider accumulator; the final sum
    // of the last voice is scaled back down in the same cycle it is formed.
    assign w_wave_ext = c_ACC_W'($signed(w_wave));
    assign w_sum      = r_acc + w_wave_ext;
    assign w_mixed    = w_sum >>> c_SHIFT;

    // ------------------------------------------------------------------------
    // Mixer FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_ACCUM;
            S_ACCUM: if (w_last)  w_state_next = S_OUT;
            S_OUT:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Mixer datapath. new_sample_ready is registered at the end of the last
    // accumulate cycle, so it is high during the OUT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx     <= '0;
            r_acc     <= '0;
            r_sample  <= '0;
            r_nsr     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_nsr <= 1'b0;
            if (generate_next_sample && play_enable && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                S_ACCUM: begin
                    r_acc <= w_sum;
                    if (w_last) begin
                        r_sample <= w_mixed[SAMPLE_W-1:0];
                        r_nsr    <= 1'b1;
                    end else begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign done_with_note   = w_done;
    assign voice_active     = w_active;
    assign sample_out       = r_sample;
    assign new_sample_ready = r_nsr;
    assign overrun          = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_poly_voice_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_poly_voice_player
// Description : Self-checking bench for poly_voice_player. A behavioural
//               model tracks voices and the mix in plain integer arithmetic;
//               a compare process checks every output each cycle, and
//               directed sequences pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_voice_player;

    localparam int VOICES   = 4;
    localparam int SAMPLE_W = 16;
    localparam int PHASE_W  = 20;
    localparam int STEP_W   = 20;
    localparam int DUR_W    = 6;
    localparam int SHIFT    = $clog2(VOICES);
    localparam int HALF     = 1 << (SAMPLE_W-1);
    localparam int FULL     = 1 << SAMPLE_W;
    localparam int QUART    = 1 << (SAMPLE_W-2);
    localparam int unsigned PMASK = (32'd1 << PHASE_W) - 32'd1;

    logic                       clk = 1'b0;
    logic                       reset = 1'b0;
    logic                       play_enable = 1'b0;
    logic [VOICES-1:0]          load_voice = '0;
    logic [VOICES*STEP_W-1:0]   step_in = '0;
    logic [VOICES*DUR_W-1:0]    duration_in = '0;
    logic [1:0]                 wave_sel = 2'd0;
    logic                       beat = 1'b0;
    logic                       generate_next_sample = 1'b0;
    logic [VOICES-1:0]          done_with_note;
    logic [VOICES-1:0]          voice_active;
    logic signed [SAMPLE_W-1:0] sample_out;
    logic                       new_sample_ready;
    logic                       overrun;

    always #5 clk = ~clk;

    poly_voice_player #(
        .VOICES(VOICES), .SAMPLE_W(SAMPLE_W), .PHASE_W(PHASE_W),
        .STEP_W(STEP_W), .DUR_W(DUR_W)
    ) dut (
        .clk(clk), .reset(reset), .play_enable(play_enable),
        .load_voice(load_voice), .step_in(step_in), .duration_in(duration_in),
        .wave_sel(wave_sel), .beat(beat),
        .generate_next_sample(generate_next_sample),
        .done_with_note(done_with_note), .voice_active(voice_active),
        .sample_out(sample_out), .new_sample_ready(new_sample_ready),
        .overrun(overrun)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    int unsigned         m_phase [VOICES];
    int unsigned         m_step  [VOICES];
    int                  m_dur   [VOICES];
    bit                  m_active[VOICES];
    logic [VOICES-1:0]   m_done;
    int                  m_pos;      // -1 idle, 0..VOICES-1 voice being summed, VOICES output
    int                  m_acc;
    logic signed [SAMPLE_W-1:0] m_sample;
    bit                  m_nsr;
    bit                  m_ovr;

    function automatic int wave_val(input int unsigned ph, input logic [1:0] ws);
        int p;
        int t;
        p = int'(ph >> (PHASE_W-SAMPLE_W));
        case (ws)
            2'd0: return (p < HALF) ? QUART : -QUART;
            2'd1: return p - HALF;
            2'd2: begin
                t = (p < HALF) ? p : (FULL - 1 - p);
                return ((2*t) % FULL) - HALF;
            end
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < VOICES; i++) begin
                m_phase[i] = 0; m_step[i] = 0; m_dur[i] = 0; m_active[i] = 0;
            end
            m_done = '0; m_pos = -1; m_acc = 0; m_sample = '0; m_nsr = 0; m_ovr = 0;
        end else begin : model_step
            int adv;
            adv = -1;
            m_nsr = 0;
            if (generate_next_sample && play_enable && m_pos != -1) m_ovr = 1;
            if (m_pos >= 0 && m_pos < VOICES) begin
                if (m_active[m_pos]) m_acc += wave_val(m_phase[m_pos], wave_sel);
                if (m_active[m_pos] && play_enable) adv = m_pos;
                if (m_pos == VOICES-1) begin
                    m_sample = SAMPLE_W'(m_acc >>> SHIFT);
                    m_nsr = 1;
                end
                m_pos++;
            end else if (m_pos == VOICES) begin
                m_pos = -1;
            end else if (generate_next_sample && play_enable) begin
                m_pos = 0;
                m_acc = 0;
            end
            m_done = '0;
            for (int i = 0; i < VOICES; i++) begin
                if (load_voice[i]) begin
                    m_step[i]   = int'(step_in[i*STEP_W +: STEP_W]);
                    m_dur[i]    = int'(duration_in[i*DUR_W +: DUR_W]);
                    m_phase[i]  = 0;
                    m_active[i] = (m_dur[i] != 0);
                    m_done[i]   = (m_dur[i] == 0);
                end else begin
                    if (adv == i) m_phase[i] = (m_phase[i] + m_step[i]) & PMASK;
                    if (beat && play_enable && m_active[i]) begin
                        m_dur[i]--;
                        if (m_dur[i] == 0) begin
                            m_active[i] = 0;
                            m_done[i]   = 1;
                        end
                    end
                end
            end
        end
    end

    // Compare process: every output against the model, away from the edge.
    always @(negedge clk) begin
        if (chk_en) begin : cmp
            logic [VOICES-1:0] exp_act;
            for (int i = 0; i < VOICES; i++) exp_act[i] = m_active[i];
            check_eq("done_with_note", int'(done_with_note), int'(m_done));
            check_eq("voice_active", int'(voice_active), int'(exp_act));
            check_eq("sample_out", int'(sample_out), int'(m_sample));
            check_eq("new_sample_ready", int'(new_sample_ready), int'(m_nsr));
            check_eq("overrun", int'(overrun), int'(m_ovr));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load_one(input int v, input int unsigned step, input int dur);
        load_voice[v] = 1'b1;
        step_in[v*STEP_W +: STEP_W] = STEP_W'(step);
        duration_in[v*DUR_W +: DUR_W] = DUR_W'(dur);
        tick();
        load_voice = '0;
    endtask

    task automatic pulse_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    // Issue one request and wait (bounded) for its sample.
    task automatic request(input string name, input bit lit, input int exp_val);
        int lat;
        int val;
        lat = -1;
        val = 0;
        generate_next_sample = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            generate_next_sample = 1'b0;
            if (new_sample_ready) begin
                lat = k;
                val = int'(sample_out);
                break;
            end
        end
        check_eq({name, "_latency"}, lat, VOICES+1);
        if (lit) check_eq(name, val, exp_val);
        tick();
    endtask

    task automatic count_ready(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            generate_next_sample = 1'b0;
            if (new_sample_ready) n++;
        end
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin : main
        int n;
        // Reset with random inputs
        reset = 1'b0;
        tick();
        chk_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            play_enable = 1'($urandom);
            load_voice  = VOICES'($urandom);
            for (int i = 0; i < VOICES; i++) begin
                step_in[i*STEP_W +: STEP_W] = STEP_W'($urandom);
                duration_in[i*DUR_W +: DUR_W] = DUR_W'($urandom);
            end
            wave_sel = 2'($urandom);
            beat = 1'($urandom);
            generate_next_sample = 1'($urandom);
            tick();
        end
        check_eq("rst_sample", int'(sample_out), 0);
        check_eq("rst_active", int'(voice_active), 0);
        check_eq("rst_ready", int'(new_sample_ready), 0);
        check_eq("rst_overrun", int'(overrun), 0);
        load_voice = '0; beat = 0; generate_next_sample = 0; wave_sel = 2'd0;
        play_enable = 1'b1;
        reset = 1'b1;
        tick();
        request("empty_sample", 1, 0);

        // Single-voice square
        load_one(0, 32'h40000, 10);
        request("sq0", 1, 4096);
        request("sq1", 1, 4096);
        request("sq2", 1, -4096);
        request("sq3", 1, -4096);

        // Duration countdown on voice 2
        load_one(2, 0, 3);
        pulse_beat();
        pulse_beat();
        check_eq("v2_active_mid", int'(voice_active[2]), 1);
        pulse_beat();
        check_eq("v2_done", int'(done_with_note), 4'b0100);
        check_eq("v2_active_end", int'(voice_active[2]), 0);
        tick();
        check_eq("v2_done_once", int'(done_with_note), 0);
        load_one(3, 0, 0);
        check_eq("v3_zero_done", int'(done_with_note), 4'b1000);
        check_eq("v3_zero_active", int'(voice_active[3]), 0);

        // Load and beat in the same cycle
        load_one(0, 32'h40000, 5);
        load_voice[1] = 1'b1;
        step_in[1*STEP_W +: STEP_W] = STEP_W'(32'h40000);
        duration_in[1*DUR_W +: DUR_W] = DUR_W'(2);
        beat = 1'b1;
        tick();
        load_voice = '0; beat = 1'b0;
        pulse_beat();
        check_eq("sim_active", int'(voice_active), 4'b0011);
        pulse_beat();
        check_eq("sim_v1_done", int'(done_with_note), 4'b0010);
        pulse_beat();
        check_eq("sim_v0_alive", int'(voice_active[0]), 1);
        pulse_beat();
        check_eq("sim_v0_done", int'(done_with_note), 4'b0001);

        // All four voices square
        for (int i = 0; i < VOICES; i++) begin
            step_in[i*STEP_W +: STEP_W] = STEP_W'(32'h40000);
            duration_in[i*DUR_W +: DUR_W] = DUR_W'(20);
        end
        load_voice = '1;
        tick();
        load_voice = '0;
        request("quad_square", 1, 16384);

        // Overrun
        check_eq("ovr_before", int'(overrun), 0);
        generate_next_sample = 1'b1; tick();
        generate_next_sample = 1'b0; tick();
        generate_next_sample = 1'b1;
        count_ready(14, n);
        check_eq("ovr_ready_count", n, 1);
        check_eq("ovr_sticky", int'(overrun), 1);

        // Freeze with play_enable low
        play_enable = 1'b0;
        n = 0;
        for (int k = 0; k < 25; k++) begin
            beat = 1'b1;
            generate_next_sample = (k % 3 == 0);
            tick();
            if (new_sample_ready) n++;
        end
        beat = 1'b0; generate_next_sample = 1'b0;
        check_eq("freeze_ready", n, 0);
        check_eq("freeze_active", int'(voice_active), 4'b1111);
        play_enable = 1'b1;

        // Saw then triangle on all four voices
        reset = 1'b0; tick(); reset = 1'b1; tick();
        for (int i = 0; i < VOICES; i++) begin
            step_in[i*STEP_W +: STEP_W] = STEP_W'(32'h4000);
            duration_in[i*DUR_W +: DUR_W] = DUR_W'(60);
        end
        load_voice = '1; wave_sel = 2'd1;
        tick();
        load_voice = '0;
        request("saw0", 1, -32768);
        request("saw1", 1, -32768 + 1024);
        request("saw2", 1, -32768 + 2048);
        wave_sel = 2'd2;
        request("tri0", 1, -26624);
        for (int k = 1; k < 64; k++) request("tri", 0, 0);

        // Reset in the middle of a mix
        generate_next_sample = 1'b1; tick();
        generate_next_sample = 1'b0; tick();
        reset = 1'b0;
        #1;
        check_eq("midreset_sample", int'(sample_out), 0);
        check_eq("midreset_active", int'(voice_active), 0);
        tick(); tick();
        reset = 1'b1;
        count_ready(10, n);
        check_eq("midreset_no_ready", n, 0);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            play_enable = ($urandom_range(0, 15) != 0);
            load_voice = ($urandom_range(0, 7) == 0) ? VOICES'($urandom) : '0;
            for (int i = 0; i < VOICES; i++) begin
                step_in[i*STEP_W +: STEP_W] = STEP_W'($urandom);
                duration_in[i*DUR_W +: DUR_W] = DUR_W'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 3) == 0) wave_sel = 2'($urandom);
            beat = ($urandom_range(0, 3) == 0);
            generate_next_sample = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 499) != 0);
            tick();
        end
        load_voice = '0; beat = 1'b0; generate_next_sample = 1'b0; reset = 1'b1;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
